ascii2dual: RTL and testbench
=============================

Name: ascii2dual

Overview:
- Inverse of the display path's binary-to-ASCII converter: parses a stream of ASCII decimal characters into a binary value.
- Used for entering settings such as trip distance, wheel circumference or clock time from a keypad or UART byte stream.
- Accepts one character per cycle on a valid/ready handshake, accumulates up to DIGITS decimal digits and emits the result on a terminator with a one-cycle valid_out pulse.
- Flags malformed or overlong input with a one-cycle error pulse.

Parameters:
- DIGITS, 4, maximum number of decimal digits accepted per number.
- WIDTH, 14, width of value_out. Must satisfy 2^WIDTH > 10^DIGITS - 1. The default holds 9999.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- char_in  input  8  ASCII character.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block accepts a character this cycle. A transfer occurs when char_valid && char_ready at the rising edge.
- value_out  output  WIDTH  last successfully parsed value, held between results.
- digit_count  output  3  number of digits in the last successful value.
- valid_out  output  1  one-cycle pulse: value_out/digit_count just updated.
- error  output  1  one-cycle pulse: the number just terminated was rejected.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, accumulator=0, count=0, value_out=0, digit_count=0, valid_out=0, error=0. char_ready=1 once in IDLE.
- Character classes:
  - DIG: 0x30–0x39, digit value = char-0x30.
  - SP: 0x20.
  - CR: 0x0D, the terminator.
  - OTHER: anything else.
- States: IDLE, ACCUM, DONE, ERR_DRAIN, ERR_FLAG. char_ready = 1 in IDLE, ACCUM and ERR_DRAIN; 0 in DONE and ERR_FLAG.
- Without a transfer, the state and accumulator hold. Gaps in char_valid are legal anywhere.
- IDLE:
  - SP: ignored, so leading blanks as produced by the display converter are skipped.
  - CR: ignored; no pulse, no output change.
  - DIG: accumulator=digit, count=1, go to ACCUM.
  - OTHER: go to ERR_DRAIN.
- ACCUM:
  - DIG with count<DIGITS: accumulator = accumulator*10 + digit, implemented as (acc<<3)+(acc<<1)+digit, WIDTH+4 bits internal; count+1.
  - DIG with count==DIGITS: go to ERR_DRAIN (overflow).
  - SP or OTHER: go to ERR_DRAIN. No embedded or trailing blanks are allowed.
  - CR: register value_out=accumulator[WIDTH-1:0] and digit_count=count on the same edge, set valid_out=1, go to DONE.
- DONE: exactly one cycle. valid_out=1, char_ready=0. Next edge: valid_out=0, accumulator=0, count=0, go to IDLE.
- ERR_DRAIN:
  - Non-CR characters: consumed and discarded.
  - CR: set error=1, go to ERR_FLAG.
- ERR_FLAG: exactly one cycle. error=1, char_ready=0. Next edge: error=0, clear accumulator and count, go to IDLE.
- Effects of an error: value_out and digit_count keep their previous good values. valid_out and error are never high together.
- Latency: the CR transfer at edge N produces valid_out (or error) high for the cycle between edges N and N+1. The next character can be accepted at edge N+2.
- Leading zeros count as digits: "0012" is 12 with digit_count=4.
- Reset asserted mid-number discards the partial accumulator; the first number after reset parses from scratch.

Test Plan:
1. Release reset; send '1','9','2','0',CR back-to-back.
   - valid_out high one cycle after the CR edge; value_out=1920; digit_count=4; error=0.
   - char_ready=0 during the pulse cycle.
2. Send ' ',' ','5','0',CR → value_out=50, digit_count=2, single valid_out pulse.
3. Send '6', three idle cycles, '9', CR; then CR alone.
   - First sequence: value_out=69.
   - The lone CR produces no valid_out or error pulse; value_out stays 69.
4. Send '1','2','3','4','5',CR.
   - error pulses one cycle after CR; no valid_out; value_out stays 69.
   - Follow with '3','3',CR → value_out=33.
5. Send '2','A','7',CR, then '2',' ',CR.
   - Each sequence yields exactly one error pulse.
   - value_out stays 33; char_ready is 1 throughout draining.
6. Send '4','7', assert reset for 2 cycles mid-stream, release, send '8',CR.
   - Outputs are 0 during reset; after the CR, value_out=8 and digit_count=1.

Source files
------------

// File: rtl/ascii2dual_if.sv
// Character stream in, parsed value out: the handshake and result bundle of ascii2dual.
// The slave modport is the parser side, the master modport the character source.
interface ascii2dual_if #(
    parameter int unsigned WIDTH = 14
);
    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_ready;
    logic [WIDTH-1:0] value_out;
    logic [2:0]       digit_count;
    logic             valid_out;
    logic             error;

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready,
        output value_out,
        output digit_count,
        output valid_out,
        output error
    );

    modport master (
        output char_in,
        output char_valid,
        input  char_ready,
        input  value_out,
        input  digit_count,
        input  valid_out,
        input  error
    );
endinterface

// File: rtl/ascii2dual.sv
// ASCII decimal parser: accumulates up to DIGITS digits and emits the value on CR,
// with a one-cycle valid_out pulse or, for malformed/overlong input, a one-cycle error pulse.
module ascii2dual #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned WIDTH  = 14
) (
    input logic         clock,
    input logic         reset,
    ascii2dual_if.slave bus
);
    localparam int unsigned AccW     = WIDTH + 4;
    localparam logic [2:0]  MaxCount = 3'(DIGITS);

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDone,
        StErrDrain,
        StErrFlag
    } state_e;

    state_e           state_q, state_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [2:0]       digits_q, digits_d;

    logic            xfer, is_dig, is_sp, is_cr;
    logic [AccW-1:0] digit_ext, acc_times10;

    assign is_dig      = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
    assign is_sp       = (bus.char_in == 8'h20);
    assign is_cr       = (bus.char_in == 8'h0D);
    assign digit_ext   = AccW'(bus.char_in[3:0]);
    assign acc_times10 = (acc_q << 3) + (acc_q << 1);
    assign xfer        = bus.char_valid && bus.char_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        value_d  = value_q;
        digits_d = digits_q;
        unique case (state_q)
            StIdle: begin
                // Blanks and bare CRs are skipped so right-aligned display text parses cleanly
                if (xfer) begin
                    if (is_dig) begin
                        acc_d   = digit_ext;
                        count_d = 3'd1;
                        state_d = StAccum;
                    end else if (!is_sp && !is_cr) begin
                        state_d = StErrDrain;
                    end
                end
            end
            StAccum: begin
                if (xfer) begin
                    if (is_cr) begin
                        value_d  = acc_q[WIDTH-1:0];
                        digits_d = count_q;
                        state_d  = StDone;
                    end else if (is_dig && (count_q < MaxCount)) begin
                        acc_d   = acc_times10 + digit_ext;
                        count_d = count_q + 3'd1;
                    end else begin
                        state_d = StErrDrain;
                    end
                end
            end
            StErrDrain: begin
                if (xfer && is_cr) begin
                    state_d = StErrFlag;
                end
            end
            StDone, StErrFlag: begin
                acc_d   = '0;
                count_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            count_q  <= '0;
            value_q  <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            value_q  <= value_d;
            digits_q <= digits_d;
        end
    end

    assign bus.char_ready  = (state_q == StIdle) || (state_q == StAccum) ||
                             (state_q == StErrDrain);
    assign bus.valid_out   = (state_q == StDone);
    assign bus.error       = (state_q == StErrFlag);
    assign bus.value_out   = value_q;
    assign bus.digit_count = digits_q;
endmodule

// File: tb/tb_ascii2dual.sv
// Self-checking bench for ascii2dual: directed scenarios plus random lines checked
// against a line-level parsing model.
module tb_ascii2dual;
    localparam int unsigned Digits = 4;
    localparam int unsigned Width  = 14;
    localparam logic [7:0]  Cr     = 8'h0D;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   exp_value;
    int   exp_count;

    ascii2dual_if #(.WIDTH(Width)) bus ();

    ascii2dual #(
        .DIGITS(Digits),
        .WIDTH (Width)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Whole-line model: kind 0 = ignored, 1 = good value, 2 = rejected.
    function automatic void model_line(input logic [7:0] q[$], output int kind,
                                       output int val, output int cnt);
        int  i;
        bit  ok;
        i = 0;
        while (i < q.size() && q[i] == 8'h20) i++;
        val = 0;
        cnt = 0;
        if (i == q.size()) begin
            kind = 0;
            return;
        end
        ok = 1'b1;
        for (int j = i; j < q.size(); j++) begin
            if (q[j] >= 8'h30 && q[j] <= 8'h39) begin
                val = val * 10 + int'(q[j] - 8'h30);
                cnt++;
            end else begin
                ok = 1'b0;
            end
        end
        if (cnt > Digits) ok = 1'b0;
        kind = ok ? 1 : 2;
    endfunction

    // Drives one character, waiting (bounded) for char_ready; returns at transfer edge + #1.
    task automatic send_char(input logic [7:0] c, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        waited         = 0;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        while (!bus.char_ready && waited < 8) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!bus.char_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: char_ready=%0b after %0d cycles, required 1", bus.char_ready,
                     waited);
        end
        @(posedge clock);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic send_line(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_char(s[i], gap);
        send_char(Cr, gap);
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        tests += 5;
        if (bus.value_out !== '0) begin fails++; $display("FAIL rst_value: got %0d required 0", bus.value_out); end
        if (bus.digit_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d required 0", bus.digit_count); end
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b required 0", bus.valid_out); end
        if (bus.error !== 1'b0) begin fails++; $display("FAIL rst_error: got %0b required 0", bus.error); end
        if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b required 1", bus.char_ready); end
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        send_line("1920", 0);
        tests += 5;
        if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b required 1", bus.valid_out); end
        if (bus.error !== 1'b0) begin fails++; $display("FAIL basic_error: got %0b required 0", bus.error); end
        if (bus.value_out !== 14'd1920) begin fails++; $display("FAIL basic_value: got %0d required 1920", bus.value_out); end
        if (bus.digit_count !== 3'd4) begin fails++; $display("FAIL basic_count: got %0d required 4", bus.digit_count); end
        if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL basic_ready: got %0b required 0", bus.char_ready); end
        @(posedge clock);
        #1;
        tests += 2;
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL basic_pulse_len: valid_out got %0b required 0", bus.valid_out); end
        if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back: got %0b required 1", bus.char_ready); end
        send_line("0012", 0);
        tests += 2;
        if (bus.value_out !== 14'd12) begin fails++; $display("FAIL lead_zero_value: got %0d required 12", bus.value_out); end
        if (bus.digit_count !== 3'd4) begin fails++; $display("FAIL lead_zero_count: got %0d required 4", bus.digit_count); end
    endtask

    task automatic test_leading_space();
        send_line("  50", 0);
        tests += 3;
        if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL space_valid: got %0b required 1", bus.valid_out); end
        if (bus.value_out !== 14'd50) begin fails++; $display("FAIL space_value: got %0d required 50", bus.value_out); end
        if (bus.digit_count !== 3'd2) begin fails++; $display("FAIL space_count: got %0d required 2", bus.digit_count); end
        @(posedge clock);
        #1;
        tests++;
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL space_pulse_len: got %0b required 0", bus.valid_out); end
    endtask

    task automatic test_gaps();
        send_char("6", 0);
        send_char("9", 3);
        send_char(Cr, 0);
        tests += 2;
        if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL gap_valid: got %0b required 1", bus.valid_out); end
        if (bus.value_out !== 14'd69) begin fails++; $display("FAIL gap_value: got %0d required 69", bus.value_out); end
        send_char(Cr, 0);
        tests += 3;
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL lone_cr_valid: got %0b required 0", bus.valid_out); end
        if (bus.error !== 1'b0) begin fails++; $display("FAIL lone_cr_error: got %0b required 0", bus.error); end
        if (bus.value_out !== 14'd69) begin fails++; $display("FAIL lone_cr_value: got %0d required 69", bus.value_out); end
    endtask

    task automatic test_overflow();
        send_line("12345", 0);
        tests += 4;
        if (bus.error !== 1'b1) begin fails++; $display("FAIL ovf_error: got %0b required 1", bus.error); end
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL ovf_valid: got %0b required 0", bus.valid_out); end
        if (bus.value_out !== 14'd69) begin fails++; $display("FAIL ovf_value: got %0d required 69", bus.value_out); end
        if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL ovf_ready: got %0b required 0", bus.char_ready); end
        @(posedge clock);
        #1;
        tests++;
        if (bus.error !== 1'b0) begin fails++; $display("FAIL ovf_pulse_len: got %0b required 0", bus.error); end
        send_line("33", 0);
        tests += 2;
        if (bus.value_out !== 14'd33) begin fails++; $display("FAIL ovf_next_value: got %0d required 33", bus.value_out); end
        if (bus.digit_count !== 3'd2) begin fails++; $display("FAIL ovf_next_count: got %0d required 2", bus.digit_count); end
    endtask

    task automatic test_bad_chars();
        send_char("2", 0);
        send_char("A", 0);
        tests++;
        if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL drain_ready: got %0b required 1", bus.char_ready); end
        send_char("7", 0);
        tests++;
        if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL drain_ready2: got %0b required 1", bus.char_ready); end
        send_char(Cr, 0);
        tests += 3;
        if (bus.error !== 1'b1) begin fails++; $display("FAIL bad_error: got %0b required 1", bus.error); end
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL bad_valid: got %0b required 0", bus.valid_out); end
        if (bus.value_out !== 14'd33) begin fails++; $display("FAIL bad_value: got %0d required 33", bus.value_out); end
        send_line("2 ", 0);
        tests += 3;
        if (bus.error !== 1'b1) begin fails++; $display("FAIL trail_sp_error: got %0b required 1", bus.error); end
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL trail_sp_valid: got %0b required 0", bus.valid_out); end
        if (bus.value_out !== 14'd33) begin fails++; $display("FAIL trail_sp_value: got %0d required 33", bus.value_out); end
    endtask

    task automatic test_reset_mid();
        send_char("4", 0);
        send_char("7", 0);
        reset = 1'b0;
        #1;
        tests += 4;
        if (bus.value_out !== '0) begin fails++; $display("FAIL midrst_value: got %0d required 0", bus.value_out); end
        if (bus.digit_count !== 3'd0) begin fails++; $display("FAIL midrst_count: got %0d required 0", bus.digit_count); end
        if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b required 0", bus.valid_out); end
        if (bus.error !== 1'b0) begin fails++; $display("FAIL midrst_error: got %0b required 0", bus.error); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        send_line("8", 0);
        tests += 3;
        if (bus.valid_out !== 1'b1) begin fails++; $display("FAIL midrst_after_valid: got %0b required 1", bus.valid_out); end
        if (bus.value_out !== 14'd8) begin fails++; $display("FAIL midrst_after_value: got %0d required 8", bus.value_out); end
        if (bus.digit_count !== 3'd1) begin fails++; $display("FAIL midrst_after_count: got %0d required 1", bus.digit_count); end
        exp_value = 8;
        exp_count = 1;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] c;
        int         kind, val, cnt, len, r;
        for (int n = 0; n < 60; n++) begin
            q   = {};
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 19);
                if (r < 14) c = 8'h30 + 8'($urandom_range(0, 9));
                else if (r < 17) c = 8'h20;
                else if (r == 17) c = 8'h2F;
                else if (r == 18) c = 8'h3A;
                else c = 8'h41 + 8'($urandom_range(0, 25));
                q.push_back(c);
            end
            for (int k = 0; k < q.size(); k++) send_char(q[k], $urandom_range(0, 2));
            send_char(Cr, $urandom_range(0, 2));
            model_line(q, kind, val, cnt);
            if (kind == 1) begin
                exp_value = val;
                exp_count = cnt;
            end
            tests += 5;
            if (bus.valid_out !== (kind == 1)) begin fails++; $display("FAIL rnd_valid[%0d]: got %0b required %0b", n, bus.valid_out, kind == 1); end
            if (bus.error !== (kind == 2)) begin fails++; $display("FAIL rnd_error[%0d]: got %0b required %0b", n, bus.error, kind == 2); end
            if (int'(bus.value_out) != exp_value) begin fails++; $display("FAIL rnd_value[%0d]: got %0d required %0d", n, bus.value_out, exp_value); end
            if (int'(bus.digit_count) != exp_count) begin fails++; $display("FAIL rnd_count[%0d]: got %0d required %0d", n, bus.digit_count, exp_count); end
            if (bus.char_ready !== (kind == 0)) begin fails++; $display("FAIL rnd_ready[%0d]: got %0b required %0b", n, bus.char_ready, kind == 0); end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        exp_value = 0;
        exp_count = 0;
        test_reset();
        test_basic();
        test_leading_space();
        test_gaps();
        test_overflow();
        test_bad_chars();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
